// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam int UART_CLK_PER_BIT_DEFAULT = 868;

  typedef logic [7:0] uart_byte_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word fall-through ring-buffer FIFO
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr_q, wr_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_COUNT);
  assign data_o  = mem_q[rd_ptr_q];

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + DEPTH_LOG2'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + (DEPTH_LOG2 + 1)'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - (DEPTH_LOG2 + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// rtl/uart_rx_buffered.sv - 8N1 UART receiver feeding a byte FIFO
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = UART_CLK_PER_BIT_DEFAULT,
  parameter int FIFO_WIDTH  = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       UART_RX,
  output uart_byte_t rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       overrun,
  output logic       frame_err
);

  localparam int TW = $clog2(CLK_PER_BIT);
  localparam logic [TW-1:0] T_HALF = TW'(CLK_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(CLK_PER_BIT - 1);

  logic       sync1_q, rxs_q, rxs_prev_q;
  rx_state_t  state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  uart_byte_t shift_q, shift_d;
  logic       push, pop, ferr_set;
  logic       fifo_full, fifo_empty;
  logic       overrun_q, frame_err_q;

  assign pop       = rx_valid && rx_ready;
  assign rx_valid  = !fifo_empty;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      rxs_prev_q  <= 1'b1;
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= UART_RX;
      rxs_q       <= sync1_q;
      rxs_prev_q  <= rxs_q;
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      overrun_q   <= overrun_q | (push && fifo_full && !pop);
      frame_err_q <= frame_err_q | ferr_set;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = (timer_q == T_LAST) ? timer_q : timer_q + TW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    ferr_set  = 1'b0;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (rxs_prev_q && !rxs_q) state_d = START;
      end
      START: begin
        // Mid-start-bit check rejects short low glitches.
        if (timer_q == T_HALF) begin
          timer_d = '0;
          if (!rxs_q) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (timer_q == T_LAST) begin
          shift_d[bit_idx_q] = rxs_q;
          timer_d            = '0;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        if (timer_q == T_LAST) begin
          timer_d = '0;
          if (rxs_q) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        timer_d = '0;
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  sync_fifo #(
    .WIDTH     (8),
    .DEPTH_LOG2(FIFO_WIDTH)
  ) u_fifo (
    .clk_i  (CLK),
    .rst_i  (RST),
    .push_i (push),
    .data_i (shift_q),
    .pop_i  (pop),
    .data_o (rx_data),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb/tb_uart_rx_buffered.sv - self-checking bench for uart_rx_buffered
module tb_uart_rx_buffered;

  localparam int CPB = 16;

  logic       clk;
  logic       RST;
  logic       UART_RX;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       overrun;
  logic       frame_err;

  uart_rx_buffered #(.CLK_PER_BIT(CPB), .FIFO_WIDTH(2)) dut (
    .CLK      (clk),
    .RST      (RST),
    .UART_RX  (UART_RX),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .overrun  (overrun),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         last_start = 0;
  int         rise_cyc = 0;
  int         valid_pairs = 0;
  logic       valid_prev = 1'b0;
  logic [7:0] got_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && !valid_prev) rise_cyc <= cyc;
    if (rx_valid && valid_prev) valid_pairs <= valid_pairs + 1;
    if (!RST && rx_valid && rx_ready) got_q.push_back(rx_data);
    valid_prev <= rx_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic [31:0] got_at(input int idx);
    if (idx < got_q.size()) return {24'h0, got_q[idx]};
    return 32'hDEAD;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int low_hold);
    UART_RX    = 1'b0;
    last_start = cyc;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      idle(CPB);
    end
    UART_RX = stop_bit;
    idle(CPB);
    if (!stop_bit) idle(low_hold);
    UART_RX = 1'b1;
  endtask

  task automatic do_reset(input string tag);
    RST     = 1'b1;
    UART_RX = 1'b1;
    idle(2);
    RST = 1'b0;
    check({tag, " rx_valid"}, 32'(rx_valid), 0);
    check({tag, " rx_data"}, 32'(rx_data), 0);
    check({tag, " overrun"}, 32'(overrun), 0);
    check({tag, " frame_err"}, 32'(frame_err), 0);
  endtask

  vec_t       vecs[6];
  int         base;
  int         pairs0;
  logic [7:0] b99;
  logic [7:0] seq[3];
  logic [7:0] exp_q[$];
  logic       exp_ferr;
  logic       rnd_done;
  logic [7:0] rb;
  logic       rgood;

  initial begin
    vecs[0] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
    vecs[3] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
    vecs[4] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h7E, 1'b1, 1'b1, 8'h7E, 1'b1};

    RST = 1'b1; UART_RX = 1'b1; rx_ready = 1'b0;
    idle(3);
    RST = 1'b0;
    check("por rx_valid", 32'(rx_valid), 0);
    check("por rx_data", 32'(rx_data), 0);
    check("por overrun", 32'(overrun), 0);
    check("por frame_err", 32'(frame_err), 0);
    idle(4);

    // Table: one frame at a time with rx_ready low, then a single-cycle pop.
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].stop_bit, 40);
      idle(4);
      check($sformatf("vec%0d rx_valid", i), 32'(rx_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d frame_err", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
      check($sformatf("vec%0d overrun", i), 32'(overrun), 0);
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d rx_data", i), 32'(rx_data), 32'(vecs[i].exp_data));
        check_range($sformatf("vec%0d latency", i), rise_cyc - last_start, 154, 158);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        check($sformatf("vec%0d empty after pop", i), 32'(rx_valid), 0);
      end
    end

    do_reset("rst1");

    // Back-to-back frames drained continuously.
    seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'hA5;
    rx_ready = 1'b1;
    base   = got_q.size();
    pairs0 = valid_pairs;
    for (int i = 0; i < 3; i++) send_frame(seq[i], 1'b1, 0);
    idle(10);
    check("b2b count", 32'(got_q.size() - base), 3);
    for (int i = 0; i < 3; i++) check($sformatf("b2b byte%0d", i), got_at(base + i), 32'(seq[i]));
    check("b2b occupancy<=1", 32'(valid_pairs - pairs0), 0);
    rx_ready = 1'b0;

    // Overrun on the fifth frame into a depth-4 FIFO.
    do_reset("rst2");
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 0);
    idle(4);
    check("ovr before fifth", 32'(overrun), 0);
    send_frame(8'h05, 1'b1, 0);
    idle(4);
    check("ovr after fifth", 32'(overrun), 1);
    base = got_q.size();
    rx_ready = 1'b1;
    idle(8);
    rx_ready = 1'b0;
    check("ovr drain count", 32'(got_q.size() - base), 4);
    for (int i = 0; i < 4; i++) check($sformatf("ovr byte%0d", i), got_at(base + i), 32'(i + 1));
    check("ovr drained", 32'(rx_valid), 0);

    // Reset 80 cycles into a frame while the FIFO holds a byte.
    send_frame(8'h5A, 1'b1, 0);
    idle(4);
    check("preload rx_valid", 32'(rx_valid), 1);
    b99 = 8'h99;
    UART_RX = 1'b0;
    idle(CPB);
    for (int i = 0; i < 4; i++) begin
      UART_RX = b99[i];
      idle(CPB);
    end
    do_reset("midframe");
    idle(250);
    check("no phantom rx_valid", 32'(rx_valid), 0);
    check("no phantom frame_err", 32'(frame_err), 0);
    send_frame(8'h42, 1'b1, 0);
    idle(4);
    check("post-rst rx_valid", 32'(rx_valid), 1);
    check("post-rst rx_data", 32'(rx_data), 32'h42);
    check("post-rst frame_err", 32'(frame_err), 0);
    rx_ready = 1'b1;
    idle(1);
    rx_ready = 1'b0;

    // Short low glitch on an idle line.
    UART_RX = 1'b0;
    idle(4);
    UART_RX = 1'b1;
    idle(200);
    check("glitch rx_valid", 32'(rx_valid), 0);
    check("glitch frame_err", 32'(frame_err), 0);
    check("glitch overrun", 32'(overrun), 0);

    // Full FIFO: the fifth stop sample coincides with a pop.
    do_reset("rst3");
    for (int i = 1; i <= 4; i++) send_frame(8'(i * 8'h11), 1'b1, 0);
    base = got_q.size();
    fork
      send_frame(8'h55, 1'b1, 0);
      begin
        repeat (154) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    idle(4);
    check("full+pop overrun", 32'(overrun), 0);
    check("full+pop popped", got_at(base), 32'h11);
    check("full+pop head", 32'(rx_data), 32'h22);
    rx_ready = 1'b1;
    idle(8);
    rx_ready = 1'b0;
    check("full+pop count", 32'(got_q.size() - base), 5);
    for (int i = 1; i < 5; i++) check($sformatf("full+pop byte%0d", i), got_at(base + i), 32'((i + 1) * 8'h11));
    check("full+pop drained", 32'(rx_valid), 0);

    // Randomized frames and consumer back-pressure against a byte-level model.
    do_reset("rst4");
    base     = got_q.size();
    exp_ferr = 1'b0;
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 12; k++) begin
          rb    = 8'($urandom);
          rgood = ($urandom_range(0, 4) != 0);
          if (rgood) exp_q.push_back(rb);
          else exp_ferr = 1'b1;
          send_frame(rb, rgood, int'($urandom_range(0, 30)));
          idle(int'($urandom_range(4, 40)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          rx_ready = 1'($urandom_range(0, 1));
          idle(1);
        end
      end
    join
    rx_ready = 1'b1;
    idle(10);
    rx_ready = 1'b0;
    check("rand count", 32'(got_q.size() - base), 32'(exp_q.size()));
    foreach (exp_q[k]) check($sformatf("rand byte%0d", k), got_at(base + k), 32'(exp_q[k]));
    check("rand frame_err", 32'(frame_err), 32'(exp_ferr));
    check("rand overrun", 32'(overrun), 0);
    check("rand drained", 32'(rx_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
